display_scan_engine: RTL and testbench

Parametrised successor to the fixed-size display datapath. It combines the pixel/line counters, ping-pong frame buffers, buffer/blank multiplexing and controller into one block. Frame geometry, channel count and channel width are all parameters. A host-side ready/valid write port fills the back buffer, and the buffers swap only at the start of vertical blank. The block sits between the display register file (CSDisplay-qualified writes) and the pixel output stage.

---
 rtl/display_scan_engine.sv | 142 ++++++++++++++
 tb/tb_display_scan_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_engine.sv
// Raster scan engine: pixel/line counters, ping-pong frame buffers, blank mux and buffer swap control.
// Latency: outputs are registered one en-cycle after the counter state; buffer read is a 1-cycle synchronous read.
// Backpressure: wr_ready drops once the back buffer is full and returns only after the swap at vblank entry.
//
// Ports:
//   clk, reset (async, active-low), en (pixel tick)
//   wr_valid/wr_ready/wr_data/wr_last : host write stream into the back buffer
//   px_valid/px_data/hblank/vblank/frame_start : aligned pixel output stream
//   rd_buf : index of the displayed buffer; rep_frame : swap point reached without a full back buffer
module display_scan_engine #(
  parameter int CW = 8,
  parameter int CH = 3,
  parameter int H_ACT = 640,
  parameter int H_BLK = 160,
  parameter int V_ACT = 480,
  parameter int V_BLK = 45,
  parameter logic [CW*CH-1:0] BLANK_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CW*CH-1:0] wr_data,
  input  logic             wr_last,
  output logic             px_valid,
  output logic [CW*CH-1:0] px_data,
  output logic             hblank,
  output logic             vblank,
  output logic             frame_start,
  output logic             rd_buf,
  output logic             rep_frame
);

  localparam int PW   = CW * CH;
  localparam int HT   = H_ACT + H_BLK;
  localparam int VT   = V_ACT + V_BLK;
  localparam int NPIX = H_ACT * V_ACT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int HW   = $clog2(HT + 1);
  localparam int VW   = $clog2(VT + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT_W = HW'(H_ACT);
  localparam logic [VW-1:0] V_LAST  = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT_W = VW'(V_ACT);
  localparam logic [VW-1:0] V_SWAP  = VW'(V_ACT - 1);
  localparam logic [AW-1:0] A_LAST  = AW'(NPIX - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_ptr;
  logic          back_full;

  logic [PW-1:0] mem [2][NPIX];

  logic h_end, v_end, active, swap_evt, accept, fill;

  always_comb begin
    h_end    = (h == H_LAST);
    v_end    = (v == V_LAST);
    active   = (h < H_ACT_W) && (v < V_ACT_W);
    // Swap point is the last pixel of the last active line, i.e. entering vertical blank.
    swap_evt = en && h_end && (v == V_SWAP);
    accept   = wr_valid && wr_ready;
    fill     = accept && (wr_last || (wr_ptr == A_LAST));
  end

  assign wr_ready = ~back_full;

  // Scan counters and the running read address (avoids a v*H_ACT+h multiplier).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h       <= '0;
      v       <= '0;
      rd_addr <= '0;
    end else if (en) begin
      if (h_end) begin
        h <= '0;
        v <= v_end ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (h_end && v_end) begin
        rd_addr <= '0;
      end else if (active) begin
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // Back-buffer fill and swap control. Only the registered back_full decides
  // the swap, so a filling beat landing on the swap cycle defers it a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_buf    <= 1'b0;
      back_full <= 1'b0;
      wr_ptr    <= '0;
    end else if (swap_evt && back_full) begin
      rd_buf    <= ~rd_buf;
      back_full <= 1'b0;
      wr_ptr    <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill) begin
        back_full <= 1'b1;
      end
    end
  end

  // Buffer storage has no reset; unwritten locations keep stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[~rd_buf][wr_ptr] <= wr_data;
    end
  end

  // Output stage: array read lands directly in px_data. Pulses clear on idle ticks,
  // levels hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_valid    <= 1'b0;
      px_data     <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      rep_frame   <= 1'b0;
    end else if (en) begin
      px_valid    <= active;
      px_data     <= active ? mem[rd_buf][rd_addr] : BLANK_VAL;
      hblank      <= (h >= H_ACT_W);
      vblank      <= (v >= V_ACT_W);
      frame_start <= (h == '0) && (v == '0);
      rep_frame   <= swap_evt && !back_full;
    end else begin
      frame_start <= 1'b0;
      rep_frame   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_engine.sv
// Bench for display_scan_engine on a 6x4 scan (4x3 active, 24-cycle frame).
// Stimulus pushes expected output words; a monitor pops and compares every clock.
module tb_display_scan_engine;

  localparam int CW = 8, CH = 3, H_ACT = 4, H_BLK = 2, V_ACT = 3, V_BLK = 1;
  localparam int HT = H_ACT + H_BLK, VT = V_ACT + V_BLK, NPIX = H_ACT * V_ACT;

  logic clk = 1'b0;
  logic reset, en, wr_valid, wr_ready, wr_last;
  logic [23:0] wr_data, px_data;
  logic px_valid, hblank, vblank, frame_start, rd_buf, rep_frame;

  display_scan_engine #(
    .CW(CW), .CH(CH), .H_ACT(H_ACT), .H_BLK(H_BLK), .V_ACT(V_ACT), .V_BLK(V_BLK),
    .BLANK_VAL(24'h000000)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .px_valid(px_valid), .px_data(px_data), .hblank(hblank), .vblank(vblank),
    .frame_start(frame_start), .rd_buf(rd_buf), .rep_frame(rep_frame)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  typedef struct packed {
    logic dc; logic fs; logic rep; logic rb; logic rdy; logic vld; logic hb; logic vb;
    logic [23:0] dat;
  } exp_t;
  exp_t sb[$];

  // Monitor statistics (en-qualified where outputs hold on idle ticks).
  int fs_cnt = 0, rep_cnt = 0, vld_cnt = 0, vb_cnt = 0, cyc = 0;
  int fs_time[$];
  logic [23:0] pix_log[$];

  initial begin : monitor
    exp_t e;
    logic [30:0] act, expv;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        if (frame_start) begin fs_cnt++; fs_time.push_back(cyc); end
        if (rep_frame) rep_cnt++;
        if (en && px_valid) begin vld_cnt++; pix_log.push_back(px_data); end
        if (en && vblank) vb_cnt++;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act  = {frame_start, rep_frame, rd_buf, wr_ready, px_valid, hblank, vblank, px_data};
        expv = {e.fs, e.rep, e.rb, e.rdy, e.vld, e.hb, e.vb, e.dat};
        if (e.dc) begin act[23:0] = '0; expv[23:0] = '0; end
        chk("out", 64'(act), 64'(expv));
      end
    end
  end

  // Reference model state.
  int mh, mv, mwp;
  logic mrb, mbf;
  logic [23:0] img [2][NPIX];
  bit known [2][NPIX];
  logic o_vld, o_hb, o_vb, o_fs, o_rep, o_dc;
  logic [23:0] o_dat;

  task automatic model_reset();
    mh = 0; mv = 0; mwp = 0; mrb = 1'b0; mbf = 1'b0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < NPIX; i++) known[b][i] = 1'b0;
    o_vld = 0; o_hb = 0; o_vb = 0; o_fs = 0; o_rep = 0; o_dc = 0; o_dat = '0;
  endtask

  task automatic step(input logic e_en, input logic wv, input logic [23:0] wd, input logic wl);
    logic swap, acc, fill;
    int idx, bk;
    exp_t x;
    en = e_en; wr_valid = wv; wr_data = wd; wr_last = wl;
    swap = e_en && (mh == HT - 1) && (mv == V_ACT - 1);
    acc  = wv && !mbf;
    fill = acc && ((mwp == NPIX - 1) || wl);
    if (e_en) begin
      o_fs  = (mh == 0) && (mv == 0);
      o_rep = swap && !mbf;
      o_hb  = (mh >= H_ACT);
      o_vb  = (mv >= V_ACT);
      o_vld = (mh < H_ACT) && (mv < V_ACT);
      if (o_vld) begin
        idx = mv * H_ACT + mh;
        o_dat = img[mrb ? 1 : 0][idx];
        o_dc  = !known[mrb ? 1 : 0][idx];
      end else begin
        o_dat = '0; o_dc = 1'b0;
      end
    end else begin
      o_fs = 1'b0; o_rep = 1'b0;
    end
    bk = mrb ? 0 : 1;
    if (acc) begin img[bk][mwp] = wd; known[bk][mwp] = 1'b1; end
    if (swap && mbf) begin mrb = !mrb; mbf = 1'b0; mwp = 0; end
    else if (acc) begin mwp++; if (fill) mbf = 1'b1; end
    if (e_en) begin
      if (mh == HT - 1) begin mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1; end
      else mh++;
    end
    x = {o_dc, o_fs, o_rep, mrb, ~mbf, o_vld, o_hb, o_vb, o_dat};
    sb.push_back(x);
    @(posedge clk); #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic goto_pos(input int th, input int tv);
    for (int i = 0; i < 2 * HT * VT && !(mh == th && mv == tv); i++) step(1'b1, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic cmp_log(input logic [23:0] expd [NPIX], input string nm, input int n_total);
    chk({nm, "_count"}, 64'(pix_log.size()), 64'(n_total));
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s[%0d]", nm, i), (i < pix_log.size()) ? 64'(pix_log[i]) : 64'hDEAD_BEEF_DEAD, 64'(expd[i]));
  endtask

  task automatic show_frame(input logic [23:0] expd [NPIX], input string nm);
    pix_log.delete();
    run(HT * VT);
    cmp_log(expd, nm, NPIX);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [23:0] e_full [NPIX];
    logic [23:0] e_late [NPIX];
    logic [23:0] e_early [NPIX];
    int r0, f0;
    for (int i = 0; i < NPIX; i++) begin
      e_full[i]  = 24'(i);
      e_late[i]  = 24'h000100 + 24'(i);
      e_early[i] = (i < 5) ? 24'hAA0000 + 24'(i) : 24'(i);
    end
    en = 0; wr_valid = 0; wr_data = '0; wr_last = 0;
    model_reset();
    reset = 1'b1; #1; reset = 1'b0; #2;
    chk("rst_outputs", 64'({frame_start, rep_frame, rd_buf, px_valid, hblank, vblank, px_data}), 64'h0);
    chk("rst_wr_ready", 64'(wr_ready), 64'h1);
    @(posedge clk); #2; reset = 1'b1;

    // Idle scan: one frame, no writes.
    run(HT * VT);
    chk("idle_fs_cnt", 64'(fs_cnt), 64'd1);
    chk("idle_rep_cnt", 64'(rep_cnt), 64'd1);
    chk("idle_valid_cnt", 64'(vld_cnt), 64'd12);
    chk("idle_vblank_cnt", 64'(vb_cnt), 64'd6);
    chk("idle_rd_buf", 64'(rd_buf), 64'h0);

    // Full frame write, 0..B.
    for (int i = 0; i < NPIX; i++) step(1'b1, 1'b1, 24'(i), 1'b0);
    chk("full_ready_low", 64'(wr_ready), 64'h0);
    chk("full_rd_buf_pre", 64'(rd_buf), 64'h0);
    r0 = rep_cnt;
    goto_pos(HT - 1, V_ACT - 1);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    chk("full_swap_rd_buf", 64'(rd_buf), 64'h1);
    chk("full_swap_ready", 64'(wr_ready), 64'h1);
    chk("full_no_rep", 64'(rep_cnt - r0), 64'h0);
    goto_pos(0, 0);
    show_frame(e_full, "frame_full");

    // Last beat lands on the swap cycle: no swap, repeat, swap a frame later.
    for (int i = 0; i < NPIX - 1; i++) step(1'b1, 1'b1, 24'h000100 + 24'(i), 1'b0);
    goto_pos(HT - 1, V_ACT - 1);
    r0 = rep_cnt;
    step(1'b1, 1'b1, 24'h00010B, 1'b0);
    chk("late_no_swap", 64'(rd_buf), 64'h1);
    chk("late_rep", 64'(rep_cnt - r0), 64'h1);
    chk("late_ready_low", 64'(wr_ready), 64'h0);
    goto_pos(HT - 1, V_ACT - 1);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    chk("late_swap", 64'(rd_buf), 64'h0);
    goto_pos(0, 0);
    show_frame(e_late, "frame_late");

    // Early wr_last on beat 5: 5 new pixels, 7 stale.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 24'hAA0000 + 24'(i), i == 4);
    chk("early_ready_low", 64'(wr_ready), 64'h0);
    goto_pos(HT - 1, V_ACT - 1);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    chk("early_swap", 64'(rd_buf), 64'h1);
    goto_pos(0, 0);
    show_frame(e_early, "frame_early");

    // en gating 1010...: two frames over 96 clocks.
    fs_time.delete();
    pix_log.delete();
    for (int i = 0; i < 4 * HT * VT; i++) step((i % 2) == 0, 1'b0, 24'h0, 1'b0);
    chk("gate_fs_cnt", 64'(fs_time.size()), 64'd2);
    chk("gate_fs_period", (fs_time.size() >= 2) ? 64'(fs_time[1] - fs_time[0]) : 64'hFFFF, 64'd48);
    cmp_log(e_early, "frame_gated", 2 * NPIX);

    // Reset mid-frame at line 1, pixel 2.
    goto_pos(2, 1);
    #3; reset = 1'b0; #1;
    chk("rstmid_outputs", 64'({frame_start, rep_frame, rd_buf, px_valid, hblank, vblank, px_data}), 64'h0);
    chk("rstmid_wr_ready", 64'(wr_ready), 64'h1);
    sb.delete();
    model_reset();
    @(posedge clk); #2; reset = 1'b1;
    f0 = fs_cnt;
    step(1'b1, 1'b0, 24'h0, 1'b0);
    chk("rstmid_first_fs", 64'(frame_start), 64'h1);
    run(HT * VT - 1);
    chk("rstmid_fs_cnt", 64'(fs_cnt - f0), 64'd1);

    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
